cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, 2-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides.
- Generalises the 4-bit CLA slice to WIDTH bits, built from GROUP-bit lookahead groups with a second lookahead level across groups.
- Adds subtract, carry/borrow-in chaining, signed saturation and status flags.
- Sits in the ALU datapath between operand fetch and writeback.

Parameters:
- WIDTH, 16: operand/result width; must be a multiple of GROUP and at least 2*GROUP.
- GROUP, 4: bits per lookahead group.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block accepts operand set this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  op_e: ADD, SUB, ADDC, SUBB
- in_cin  input  1  carry-in (ADDC) or borrow-in (SUBB); ignored for ADD/SUB
- in_sat  input  1  1 = saturate signed result on overflow
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  unsigned carry-out; for SUB/SUBB, 1 = no borrow
- out_ovfl  output  1  signed overflow, set before saturation
- out_zero  output  1  out_sum == 0, after saturation
- out_neg  output  1  out_sum MSB, after saturation

Behaviour:
- Transfer occurs on a clock edge where valid and ready are both high.
- Stage 1 (S1), on accept: register A; register B' (B for ADD/ADDC, ~B for SUB/SUBB); register effective carry-in c0 (ADD=0, SUB=1, ADDC=cin, SUBB=~cin); register sat. Also register per-group P/G and per-bit p/g computed from A and B'.
- Stage 2 (S2): from registered P/G, compute group carries C[k+1] = G[k] | P[k]&C[k], flattened lookahead, no ripple across groups.
  - Compute the sum and cout = C[WIDTH/GROUP].
  - ovfl = carry into MSB XOR carry out of MSB.
  - If sat && ovfl: sum forced to 0x7F..F when A MSB = 0, else 0x80..0.
  - zero and neg are derived from the final sum. All results are registered.
- Latency: exactly 2 cycles from input accept to out_valid with no stall. Throughput: 1 per cycle.
- Flow control:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv, combinational from out_ready; no combinational path from in_valid.
- Stall: when out_ready = 0 and both stages are full, in_ready = 0. S1/S2 contents hold stable, and out_* hold stable while out_valid = 1 and out_ready = 0.
- Bubbles: an empty stage is filled regardless of downstream state. A stage's valid clears when its data advances and no new data enters.
- Simultaneous accept and drain in the same cycle is legal; no loss, no duplication, order preserved.
- Reset (async assert, sync-released by the system):
  - s1_valid = s2_valid = out_valid = 0.
  - out_sum = 0; out_cout = out_ovfl = out_neg = 0; out_zero = 0.
  - in_ready = 1 in the first cycle after release.
  - In-flight data is discarded when reset is asserted mid-operation.
- Out-of-range parameters (WIDTH % GROUP != 0) trigger an elaboration-time $error.

Decomposition:
- Package cla_pkg: typedef enum logic [1:0] op_e {OP_ADD=0, OP_SUB=1, OP_ADDC=2, OP_SUBB=3}; localparam default GROUP.
- Sub-module cla_group, parametrised by GROUP:
  - Inputs: a, b, cin. Outputs: sum, group P, group G, carry into MSB.
  - Generated WIDTH/GROUP times in S1 (P/G) and S2 (sum).

Test Plan (WIDTH=16, GROUP=4):
1. ADD 0x7FFF+0x0001, sat=0, out_ready=1 -> two cycles later: sum=0x8000, ovfl=1, cout=0, neg=1, zero=0.
2. Same operands, sat=1 -> sum=0x7FFF, ovfl=1, neg=0. Also SUB 0x8000-0x0001, sat=1 -> sum=0x8000, ovfl=1.
3. SUB 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovfl=0, neg=1. Then SUBB 0x0005-0x0003 with cin=1 -> sum=0x0001, cout=1.
4. ADDC 0xFFFF+0x0000 cin=1 -> sum=0x0000, cout=1, zero=1. Also ADDC 0x0FFF+0x0001 cin=0 -> 0x1000, exercising the cross-group carry.
5. Backpressure: out_ready=0 with 4 back-to-back valid inputs -> 2 accepted, in_ready=0 from the 3rd edge, out_* stable. Raise out_ready -> all 4 results emerge in order, one per cycle, none lost or duplicated.
6. Assert rst_n=0 with both stages full -> out_valid=0 and out_sum=0 immediately (async). After release: in_ready=1, no stale result ever appears.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and defaults for the pipelined CLA adder/subtractor
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_SUBB = 2'd3
  } op_e;

  localparam int CLA_GROUP = 4;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit lookahead slice: sum, group propagate/generate, carry into MSB
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             pg,
  output logic             gg,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] is the carry into bit i; the loop unrolls to per-bit lookahead terms
  always_comb begin
    c[0] = cin;
    for (int i = 1; i < GROUP; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
  end

  always_comb begin
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gg = g[i] | (p[i] & gg);
    end
  end

  assign pg    = &p;
  assign sum   = p ^ c;
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - 2-stage pipelined two-level CLA add/sub with saturation and flags
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovfl,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < 2 * GROUP) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and at least 2*GROUP");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  logic [NG-1:0]    pg_in, gg_in;
  logic [WIDTH-1:0] s1_sum_unused;
  logic [NG-1:0]    s1_cmsb_unused;

  logic             s1_valid, s1_c0, s1_sat;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [NG-1:0]    s1_pg, s1_gg;
  logic             s1_adv, s2_adv;

  assign op    = op_e'(in_op);
  assign b_eff = (op == OP_SUB || op == OP_SUBB) ? ~in_b : in_b;

  always_comb begin
    case (op)
      OP_ADD:  c0_in = 1'b0;
      OP_SUB:  c0_in = 1'b1;
      OP_ADDC: c0_in = in_cin;
      default: c0_in = ~in_cin;
    endcase
  end

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group #(.GROUP(GROUP)) u_pg (
      .a     (in_a[k*GROUP +: GROUP]),
      .b     (b_eff[k*GROUP +: GROUP]),
      .cin   (1'b0),
      .sum   (s1_sum_unused[k*GROUP +: GROUP]),
      .pg    (pg_in[k]),
      .gg    (gg_in[k]),
      .c_msb (s1_cmsb_unused[k])
    );
  end

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c0    <= 1'b0;
      s1_sat   <= 1'b0;
      s1_pg    <= '0;
      s1_gg    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= b_eff;
        s1_c0  <= c0_in;
        s1_sat <= in_sat;
        s1_pg  <= pg_in;
        s1_gg  <= gg_in;
      end
    end
  end

  logic [NG:0]      gc;
  logic [WIDTH-1:0] raw_sum, sat_val, fin_sum;
  logic [NG-1:0]    grp_cmsb;
  logic [NG-1:0]    s2_pg_unused, s2_gg_unused;
  logic             unused_cmsb;
  logic             cout, ovfl;

  // Second lookahead level: every group carry depends only on registered P/G and c0
  always_comb begin
    gc[0] = s1_c0;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = s1_gg[k] | (s1_pg[k] & gc[k]);
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group #(.GROUP(GROUP)) u_sum (
      .a     (s1_a[k*GROUP +: GROUP]),
      .b     (s1_b[k*GROUP +: GROUP]),
      .cin   (gc[k]),
      .sum   (raw_sum[k*GROUP +: GROUP]),
      .pg    (s2_pg_unused[k]),
      .gg    (s2_gg_unused[k]),
      .c_msb (grp_cmsb[k])
    );
  end

  assign unused_cmsb = ^grp_cmsb[NG-2:0];
  assign cout        = gc[NG];
  assign ovfl        = grp_cmsb[NG-1] ^ cout;
  assign sat_val     = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign fin_sum     = (s1_sat && ovfl) ? sat_val : raw_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovfl  <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= fin_sum;
        out_cout <= cout;
        out_ovfl <= ovfl;
        out_zero <= (fin_sum == '0);
        out_neg  <= fin_sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - randomized and directed self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_op;
  logic          in_cin, in_sat;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout, out_ovfl, out_zero, out_neg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drained = 0;
  bit rnd_done = 0;

  typedef struct {
    logic [19:0] r;
    int          n;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovfl  (out_ovfl),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  // Reference result from signed/unsigned integer arithmetic: {sum, cout, ovfl, zero, neg}
  function automatic logic [19:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sat);
    int sa, sb, ua, ub, ci, sr, ur;
    logic co, ov;
    logic [15:0] s;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ci = cin;
    case (op)
      2'd0:    begin sr = sa + sb;      ur = ua + ub;      end
      2'd1:    begin sr = sa - sb;      ur = ua - ub;      end
      2'd2:    begin sr = sa + sb + ci; ur = ua + ub + ci; end
      default: begin sr = sa - sb - ci; ur = ua - ub - ci; end
    endcase
    co = op[0] ? (ur >= 0) : (ur > 65535);
    ov = (sr > 32767) || (sr < -32768);
    s  = (sat && ov) ? ((sr > 0) ? 16'h7FFF : 16'h8000) : ur[15:0];
    return {s, co, ov, (s == 16'h0000), s[15]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_result: got sum %h with nothing outstanding at cycle %0d", out_sum, cyc);
        end else begin
          if ({out_sum, out_cout, out_ovfl, out_zero, out_neg} !== exp_q[0].r || cyc < exp_q[0].n + 2) begin
            n_err++;
            $display("FAIL result: got %h expected %h (accepted cycle %0d, now %0d)",
                     {out_sum, out_cout, out_ovfl, out_zero, out_neg}, exp_q[0].r, exp_q[0].n, cyc);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            drained++;
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].n + 2) begin
        n_cmp++;
        n_err++;
        $display("FAIL late_result: out_valid 0, expected %h accepted at cycle %0d, now %0d", exp_q[0].r, exp_q[0].n, cyc);
      end
      if (in_valid && in_ready)
        exp_q.push_back('{model(in_op, in_a, in_b, in_cin, in_sat), cyc});
    end
  end

  // Drives one operand set and returns at 1 time unit after the edge that accepted it
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sat);
    int t;
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_cin = cin; in_sat = sat;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_one(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sat, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez, input logic en);
    send(op, a, b, cin, sat);
    @(negedge clk);
    chk({name, "_not_yet"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(name, {12'd0, out_sum, out_cout, out_ovfl, out_zero, out_neg}, {12'd0, es, ec, eo, ez, en});
    @(posedge clk);
    #1;
  endtask

  logic [19:0] held;
  int d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = 2'd0; in_cin = 1'b0; in_sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outs", {12'd0, out_sum, out_cout, out_ovfl, out_zero, out_neg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    do_one("add_ovfl",      2'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    do_one("add_sat",       2'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    do_one("sub_sat",       2'd1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    do_one("sub_borrow",    2'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_one("subb_cin",      2'd3, 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_one("addc_wrap",     2'd2, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_one("addc_crossgrp", 2'd2, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: only two operand sets fit while the sink is stalled
    out_ready = 1'b0;
    d0 = drained;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        @(negedge clk); chk("bp_ready0", {31'd0, in_ready}, 32'd1);
        @(negedge clk); chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        @(negedge clk); chk("bp_ready2", {31'd0, in_ready}, 32'd0);
        held = {out_sum, out_cout, out_ovfl, out_zero, out_neg};
        repeat (3) begin
          @(negedge clk);
          chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_stall_hold", {12'd0, out_sum, out_cout, out_ovfl, out_zero, out_neg}, {12'd0, held});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("bp_drained", drained - d0, 32'd4);
    @(posedge clk);
    #1;

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(2'd0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    send(2'd1, 16'h5555, 16'h0001, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_sum", {16'd0, out_sum}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          logic [15:0] a, b;
          a = 16'($urandom);
          b = 16'($urandom);
          case ($urandom_range(7))
            0: a = 16'h7FFF;
            1: a = 16'h8000;
            2: b = 16'hFFFF;
            3: b = 16'h0000;
            default: ;
          endcase
          send(2'($urandom_range(3)), a, b, 1'($urandom), 1'($urandom));
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || out_valid); t++)
      @(negedge clk);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
